// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions: opcode constants, ALU operation classes,
// and the packed control bundle handed from decode to execute.
package legv8_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ8 = 8'b10110100;
  localparam logic [5:0]  OP_B6   = 6'b000101;
  localparam logic [10:0] OP_HALT = 11'h7FF;

  typedef enum logic [1:0] {
    ALUOP_MEM = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_R   = 2'b10
  } aluop_e;

  typedef struct packed {
    logic   reg2loc;
    logic   alusrc;
    logic   memtoreg;
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   branch;
    logic   uncondbranch;
    aluop_e aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_MEM};

  function automatic logic is_halt(input logic [31:0] instr);
    return instr[31:21] == OP_HALT;
  endfunction

endpackage

// File: rtl/legv8_control.sv
// LEGv8 main-control decode: purely combinational from one instruction word.
// Optional macro IFID_ILLEGAL_TRAP_EN enables the unknown-opcode flag;
// without it the flag is constant 0 and unknown opcodes decode as NOPs.
module legv8_control
  import legv8_pkg::*;
(
  input  logic [31:0] instruction,
  output ctrl_t       ctrl,
  output logic [63:0] imm,
  output logic        halt,
  output logic        illegal
);

  logic [10:0] op;
  assign op = instruction[31:21];

  // First-match decode of control, immediate and halt/illegal flags.
  always_comb begin
    ctrl    = CTRL_NOP;
    imm     = '0;
    halt    = 1'b0;
    illegal = 1'b0;
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) begin
      ctrl.regwrite = 1'b1;
      ctrl.aluop    = ALUOP_R;
    end else if (op == OP_LDUR) begin
      ctrl.alusrc   = 1'b1;
      ctrl.memtoreg = 1'b1;
      ctrl.regwrite = 1'b1;
      ctrl.memread  = 1'b1;
      imm           = {{55{instruction[20]}}, instruction[20:12]};
    end else if (op == OP_STUR) begin
      ctrl.reg2loc  = 1'b1;
      ctrl.alusrc   = 1'b1;
      ctrl.memwrite = 1'b1;
      imm           = {{55{instruction[20]}}, instruction[20:12]};
    end else if (instruction[31:24] == OP_CBZ8) begin
      ctrl.reg2loc  = 1'b1;
      ctrl.branch   = 1'b1;
      ctrl.aluop    = ALUOP_BR;
      imm           = {{45{instruction[23]}}, instruction[23:5]};
    end else if (instruction[31:26] == OP_B6) begin
      ctrl.uncondbranch = 1'b1;
      imm               = {{38{instruction[25]}}, instruction[25:0]};
    end else if (is_halt(instruction)) begin
      halt = 1'b1;
    end else begin
`ifdef IFID_ILLEGAL_TRAP_EN
      illegal = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/if_id_decode.sv
// IF/ID pipeline register with LEGv8 decode, HALT freeze and accept counter.
// Optional macro IFID_ILLEGAL_TRAP_EN: an unknown opcode in ID raises
// id_illegal and freezes the front end on the following edge like a HALT.
module if_id_decode
  import legv8_pkg::*;
#(
  parameter int unsigned PC_W  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [31:0]      if_instruction,
  input  logic [PC_W-1:0]  if_pc,
  input  logic             stall,
  input  logic             flush,
  output logic             id_valid,
  output logic [PC_W-1:0]  id_pc,
  output logic [31:0]      id_instruction,
  output logic [10:0]      id_opcode,
  output logic [4:0]       id_rn,
  output logic [4:0]       id_rm,
  output logic [4:0]       id_rd,
  output logic [63:0]      id_imm,
  output logic             id_reg2loc,
  output logic             id_alusrc,
  output logic             id_memtoreg,
  output logic             id_regwrite,
  output logic             id_memread,
  output logic             id_memwrite,
  output logic             id_branch,
  output logic             id_uncondbranch,
  output logic [1:0]       id_aluop,
  output logic             id_halt,
  output logic             halted,
  output logic             id_illegal,
  output logic [CNT_W-1:0] id_count
);

  ctrl_t dec_ctrl;
  logic  dec_halt;
  logic  dec_illegal;
  logic  trap;
  logic  frozen;
  logic  accept;

  legv8_control u_control (
    .instruction (id_instruction),
    .ctrl        (dec_ctrl),
    .imm         (id_imm),
    .halt        (dec_halt),
    .illegal     (dec_illegal)
  );

`ifdef IFID_ILLEGAL_TRAP_EN
  assign trap = id_valid & dec_illegal;
`else
  assign trap = 1'b0;
`endif

  // A pending trap must also block the accept on the edge that sets halted,
  // otherwise the offending instruction would be overwritten before freezing.
  assign frozen = halted | trap;
  assign accept = if_valid & ~stall & ~flush & ~frozen;

  // ID register, accept counter and sticky halt; reset > flush > stall > accept > bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid       <= 1'b0;
      id_pc          <= '0;
      id_instruction <= '0;
      id_count       <= '0;
      halted         <= 1'b0;
    end else begin
      if (flush) begin
        id_valid <= 1'b0;
      end else if (stall) begin
        id_valid <= id_valid;
      end else if (accept) begin
        id_valid       <= 1'b1;
        id_pc          <= if_pc;
        id_instruction <= if_instruction;
        id_count       <= id_count + CNT_W'(1);
      end else if (!frozen) begin
        id_valid <= 1'b0;
      end
      if ((accept && is_halt(if_instruction)) || (trap && !flush)) begin
        halted <= 1'b1;
      end
    end
  end

  assign id_opcode = id_instruction[31:21];
  assign id_rm     = id_instruction[20:16];
  assign id_rn     = id_instruction[9:5];
  assign id_rd     = id_instruction[4:0];

  assign id_reg2loc      = id_valid & dec_ctrl.reg2loc;
  assign id_alusrc       = id_valid & dec_ctrl.alusrc;
  assign id_memtoreg     = id_valid & dec_ctrl.memtoreg;
  assign id_regwrite     = id_valid & dec_ctrl.regwrite;
  assign id_memread      = id_valid & dec_ctrl.memread;
  assign id_memwrite     = id_valid & dec_ctrl.memwrite;
  assign id_branch       = id_valid & dec_ctrl.branch;
  assign id_uncondbranch = id_valid & dec_ctrl.uncondbranch;
  assign id_aluop        = {2{id_valid}} & dec_ctrl.aluop;
  assign id_halt         = id_valid & dec_halt;
  assign id_illegal      = id_valid & dec_illegal;

endmodule

// File: doc/if_id_decode.md
Name: if_id_decode

Overview:
- IF/ID pipeline register plus LEGv8 main-control decode; sits directly downstream of instruction fetch.
- Fetch presents a 32-bit little-endian-assembled instruction and its 64-bit PC.
- This block registers them and decodes opcode, register fields, sign-extended immediate and datapath control for the execute stage.
- Detects HALT (opcode 11'h7FF) and freezes the front end.

Parameters:
- PC_W, 64, PC width in bits.
- CNT_W, 32, width of the accepted-instruction counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_valid  in  1  fetch presents a valid instruction this cycle.
- if_instruction  in  32  fetched instruction.
- if_pc  in  PC_W  byte address of if_instruction.
- stall  in  1  hold the ID register contents.
- flush  in  1  squash the ID register (taken branch).
- id_valid  out  1  ID register holds a live instruction.
- id_pc  out  PC_W  registered PC.
- id_instruction  out  32  registered instruction.
- id_opcode  out  11  id_instruction[31:21].
- id_rn, id_rm, id_rd  out  5 each  [9:5], [20:16], [4:0].
- id_imm  out  64  sign-extended immediate, unshifted.
- id_reg2loc, id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_uncondbranch  out  1 each  control.
- id_aluop  out  2  ALU operation class.
- id_halt  out  1  HALT is in the ID register.
- halted  out  1  sticky; front end frozen.
- id_illegal  out  1  unknown opcode flag (see Optional Feature).
- id_count  out  CNT_W  instructions accepted since reset.

Behaviour:
- One clock; reset is synchronous and active-high.
- On reset:
  - all outputs are 0.
  - id_instruction is 32'h0.
  - halted is 0 and id_count is 0.
- Latency: 1 cycle. An instruction accepted at edge N appears on id_* after edge N.
- Accept condition: if_valid & !stall & !flush & !halted.
  - On accept: load pc/instruction, id_valid=1, id_count++. id_count wraps modulo 2^CNT_W.
- Priority per edge: reset > flush > stall > accept > bubble.
  - flush: id_valid=0, regardless of stall.
  - stall without flush: all id_* hold their values, and id_count holds.
  - !if_valid with no stall: id_valid=0 (bubble).
- Control outputs, id_halt and id_illegal are gated by id_valid. They are all 0 when id_valid=0.
- Decode is combinational from the registered instruction (sub-module). First match wins:
  - R-type: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 → regwrite=1, aluop=10, others 0.
  - LDUR 11111000010 → alusrc=1, memtoreg=1, regwrite=1, memread=1, aluop=00.
  - STUR 11111000000 → reg2loc=1, alusrc=1, memwrite=1, aluop=00.
  - CBZ, bits[31:24]=10110100 → reg2loc=1, branch=1, aluop=01.
  - B, bits[31:26]=000101 → uncondbranch=1.
  - HALT, 11 ones → id_halt=1, all control 0.
  - Anything else → all control 0 (NOP).
- id_imm:
  - D-type: sext([20:12]).
  - CBZ: sext([23:5]).
  - B: sext([25:0]).
  - otherwise 0.
  - Shift-left-2 is the branch adder's job.
- Halt:
  - The edge that loads a HALT sets halted=1.
  - Afterwards no further accepts occur; the HALT stays in the ID register with id_valid=1.
  - Only reset clears halted.
  - A flush in the same cycle as the HALT load wins: the HALT is not loaded and halted stays 0.
- Reset mid-stall or while halted: returns to the reset state on that edge.

Optional Feature:
- Macro IFID_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode with id_valid=1 drives id_illegal=1.
  - On the next edge halted is set, unless a flush occurs on that edge.
  - The trap is then treated as a HALT: front end frozen, instruction held.
- Undefined: id_illegal is tied 0 and unknown opcodes behave as NOPs.

Decomposition:
- Package legv8_pkg holds:
  - opcode constants: OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR, OP_CBZ8, OP_B6, OP_HALT.
  - ALUOP_MEM/BR/R encodings.
  - a ctrl_t packed struct of the nine control fields.
- One sub-module, legv8_control: purely combinational; 32-bit instruction in, ctrl_t, imm, halt and illegal out.
- The top level holds the register, counter and halt logic.

Test Plan:
- Reset, then if_valid=1 with instr 0x8B020020 (ADD X0,X1,X2), pc=0 → next cycle:
  - id_valid=1, rd=0, rn=1, rm=2.
  - regwrite=1, aluop=10, id_count=1.
- LDUR 0xF84083E1 at pc=4 → alusrc=1, memread=1, memtoreg=1, id_imm=8, rd=1, rn=31.
- CBZ with imm19=all ones (0xB4FFFFE0) → branch=1, reg2loc=1, id_imm=64'hFFFF_FFFF_FFFF_FFFF.
- Stall held 3 cycles while if_instruction changes → id_* unchanged and id_count unchanged. Stall+flush together → id_valid=0.
- HALT 0xFFE00000 then ADD stream → id_halt=1 and halted=1 after one edge. Later ADDs are ignored; id_count frozen. Reset clears everything.
- With IFID_ILLEGAL_TRAP_EN, instr 0x00000000 → id_illegal=1, then halted=1. Without the macro → NOP, id_illegal=0, halted=0.
